// File: rtl/hack_io_pkg.sv
// Shared definitions for Hack memory-mapped I/O peripherals:
// status/control bit positions, TX state encoding and default timing.
package hack_io_pkg;

  localparam int STATUS_FULL     = 0;
  localparam int STATUS_BUSY     = 1;
  localparam int STATUS_OVERFLOW = 2;

  localparam int CTRL_BIT = 15;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-around pointers and an explicit count.
// Handshake: push is accepted when not full or when a pop happens in the same
// cycle; pop is honoured only when not empty; rdata always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: decoder writes feed a character FIFO,
// a four-state serialiser drives tx, and a status word reports full/busy/overflow.
module uart_tx_port
  import hack_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state;
  tx_state_e     state_n;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          tx_q;
  logic          tx_n;
  logic          overflow;
  logic          overflow_n;

  logic          push_req;
  logic          ctrl_wr;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  assign push_req    = load && !in[CTRL_BIT];
  assign ctrl_wr     = load && in[CTRL_BIT];
  assign baud_last   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign unused_bits = ^{in[14:8], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx_q     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      sh       <= sh_n;
      tx_q     <= tx_n;
      overflow <= overflow_n;
    end
  end

  // Pops only look at the registered FIFO state, so a character pushed in
  // STOP's last cycle waits for the next IDLE check.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    pop     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_rdata;
          baud_n  = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = TX_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) state_n = TX_STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_rdata;
            state_n = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // tx is registered from the next-state view so it lines up with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = sh_n[bit_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_comb begin
    overflow_n = overflow;
    if (ctrl_wr)
      overflow_n = 1'b0;
    else if (push_req && fifo_full && !pop)
      overflow_n = 1'b1;
  end

  always_comb begin
    out                  = '0;
    out[STATUS_FULL]     = fifo_full;
    out[STATUS_BUSY]     = (state != TX_IDLE) || !fifo_empty;
    out[STATUS_OVERFLOW] = overflow;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus random writes,
// compared every cycle against a frame-level model of the transmitter.
module tb_uart_tx_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;
  logic        tx;

  int n_cmp;
  int n_bad;

  // Model: characters waiting in the FIFO, and the remaining line samples of
  // the frame being sent (front = value currently on tx).
  logic [7:0] exp_q[$];
  logic       line_q[$];
  logic       m_ovf;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .in    (in),
    .out   (out),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_frame(input logic [7:0] c);
    logic b;
    line_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k == 9) b = 1'b1;
      else             b = c[k-1];
      for (int r = 0; r < CPB; r++) line_q.push_back(b);
    end
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] d, input logic rs);
    logic popped;
    logic [7:0] c;
    popped = 1'b0;
    if (rs) begin
      exp_q.delete();
      line_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (line_q.size() <= 1 && exp_q.size() > 0) begin
        c = exp_q.pop_front();
        build_frame(c);
        popped = 1'b1;
      end else if (line_q.size() > 0) begin
        void'(line_q.pop_front());
      end
      if (ld) begin
        if (d[15])
          m_ovf = 1'b0;
        else if (exp_q.size() < DEPTH || popped)
          exp_q.push_back(d[7:0]);
        else
          m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic rs);
    logic        e_tx;
    logic [15:0] e_out;
    @(negedge clk);
    load  = ld;
    in    = d;
    reset = rs;
    @(posedge clk);
    model_edge(ld, d, rs);
    #1;
    load  = 1'b0;
    in    = $urandom_range(0, 16'hffff) & 16'h7fff;
    reset = 1'b0;
    e_tx  = (line_q.size() > 0) ? line_q[0] : 1'b1;
    e_out = '0;
    e_out[0] = (exp_q.size() == DEPTH);
    e_out[1] = (line_q.size() > 0) || (exp_q.size() > 0);
    e_out[2] = m_ovf;
    check("tx", {15'd0, tx}, {15'd0, e_tx});
    check("status", out, e_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic write_char(input logic [7:0] c);
    logic [6:0] junk;
    junk = 7'($urandom_range(0, 127));
    tick(1'b1, {1'b0, junk, c}, 1'b0);
  endtask

  logic [7:0] chars [6];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    m_ovf  = 1'b0;
    load   = 1'b0;
    in     = '0;
    reset  = 1'b1;
    chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43;
    chars[3] = 8'h44; chars[4] = 8'h45; chars[5] = 8'h46;

    // Reset and idle line.
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000, 1'b1);
    idle(50);

    // Single 0x55 frame, then quiet line.
    tick(1'b1, 16'h0055, 1'b0);
    idle(45);

    // Six back-to-back writes (sixth overflows), control clear at step 10,
    // write during the STOP last cycle of frame A with the FIFO full.
    for (int k = 0; k < 6; k++) write_char(chars[k]);
    for (int k = 6; k <= 40; k++) begin
      if (k == 10) tick(1'b1, 16'h8000, 1'b0);
      else         tick(1'b0, 16'h0000, 1'b0);
    end
    write_char(8'h47);
    idle(210);

    // Random traffic with occasional control writes, no polling.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)       write_char(8'($urandom_range(0, 255)));
      else if ($urandom_range(0, 39) == 0) tick(1'b1, 16'h8000 | 16'($urandom_range(0, 16'h7fff)), 1'b0);
      else                                 idle(1);
    end
    idle(250);

    // Reset during DATA bit 3, then a clean random frame.
    write_char(8'($urandom_range(0, 255)));
    idle(18);
    tick(1'b0, 16'h0000, 1'b1);
    idle(5);
    write_char(8'($urandom_range(0, 255)));
    idle(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
